// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan arbiter and digit decoder.
// Optional build macro used by users of this package: SSEG_LEADING_ZERO_BLANK_EN.
package sseg_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScanA = 2'd1,
    StScanB = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] EN_OFF    = 6'b111111;

  // Active-low segment patterns for digits 0..9; bit 7 (dp) is off in every entry.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Marks the contiguous run of zero nibbles from the top used digit downward.
  // Digit 0 is never marked so an all-zero value still shows a single 0.
  function automatic logic [5:0] lead_zero_mask(input logic [23:0] bcd, input int num_digits);
    logic [5:0] mask;
    logic       run;
    mask = '0;
    run  = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      if (i < num_digits) begin
        run     = run && (bcd[4*i +: 4] == 4'h0);
        mask[i] = run;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/sseg_scan_arbiter_if.sv
// Requester/display bundle for sseg_scan_arbiter.
// master: requester/display side; slave: the arbiter.
interface sseg_scan_arbiter_if;

  logic        a_req;
  logic [23:0] a_bcd;
  logic [5:0]  a_dp;
  logic        b_req;
  logic [23:0] b_bcd;
  logic [5:0]  b_dp;
  logic        a_gnt;
  logic        b_gnt;
  logic [7:0]  sseg;
  logic [5:0]  en;
  logic        frame_done;

  modport master (
    output a_req, a_bcd, a_dp, b_req, b_bcd, b_dp,
    input  a_gnt, b_gnt, sseg, en, frame_done
  );

  modport slave (
    input  a_req, a_bcd, a_dp, b_req, b_bcd, b_dp,
    output a_gnt, b_gnt, sseg, en, frame_done
  );

endinterface

// File: rtl/sseg_digit_decode.sv
// Combinational nibble-to-segment decoder (active-low, bit 7 = dp).
// Non-decimal nibbles and blanked digits light no segments; dp is always honoured.
module sseg_digit_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] sseg_o
);

  logic [6:0] seg;

  // Table lookup for 0..9, everything else dark.
  always_comb begin
    seg = SEG_BLANK[6:0];
    if (!blank_i && (nibble_i <= 4'd9)) begin
      seg = SEG_TABLE[nibble_i][6:0];
    end
    sseg_o = {~dp_i, seg};
  end

endmodule

// File: rtl/sseg_scan_arbiter.sv
// Time-multiplexed scan controller for a 6-digit active-low display shared by
// a normal requester (A) and a priority requester (B). Ownership changes only
// at frame boundaries; owner data is snapshotted once per frame.
// Optional macro: SSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits at snapshot.
module sseg_scan_arbiter
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 25000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned B_MAX_FRAMES = 4
) (
  input logic                clk,
  input logic                rst_n,
  sseg_scan_arbiter_if.slave bus_io
);

  localparam int unsigned SlotW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned StreakW = (B_MAX_FRAMES > 0) ? $clog2(B_MAX_FRAMES + 1) : 1;

  localparam logic [SlotW-1:0]   LastSlot  = SlotW'(SCAN_DIV - 1);
  localparam logic [SlotW-1:0]   BlankEnd  = SlotW'(BLANK_CYCLES);
  localparam logic [2:0]         LastDigit = 3'(NUM_DIGITS - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(B_MAX_FRAMES);

  state_t               state_q, state_d;
  logic [SlotW-1:0]     slot_q, slot_d;
  logic [2:0]           digit_q, digit_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic [23:0]          bcd_q, bcd_d;
  logic [5:0]           dp_q, dp_d;
  logic [5:0]           blank_q, blank_d;
  logic                 done_q, done_d;

  logic                 win_a, win_b;
  logic [StreakW-1:0]   streak_arb;
  logic [23:0]          snap_bcd;
  logic [5:0]           snap_dp;
  logic [5:0]           snap_blank;
  logic                 take;
  logic                 drive;
  logic [7:0]           dec_sseg;

  // Arbitration: B has priority, but after StreakMax consecutive B frames a
  // waiting A gets one frame. The streak saturates so it never wraps.
  always_comb begin
    win_a      = 1'b0;
    win_b      = 1'b0;
    streak_arb = streak_q;
    if (bus_io.b_req && bus_io.a_req && (B_MAX_FRAMES != 0) && (streak_q == StreakMax)) begin
      win_a      = 1'b1;
      streak_arb = '0;
    end else if (bus_io.b_req) begin
      win_b = 1'b1;
      if (streak_q != StreakMax) begin
        streak_arb = streak_q + StreakW'(1);
      end
    end else if (bus_io.a_req) begin
      win_a      = 1'b1;
      streak_arb = '0;
    end
  end

  // Snapshot source: the winner's data plus its leading-zero blank mask.
  always_comb begin
    snap_bcd = win_b ? bus_io.b_bcd : bus_io.a_bcd;
    snap_dp  = win_b ? bus_io.b_dp  : bus_io.a_dp;
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  assign snap_blank = lead_zero_mask(snap_bcd, int'(NUM_DIGITS));
`else
  assign snap_blank = '0;
`endif

  // Scan sequencing: slot and digit counters, frame boundary re-arbitration.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    digit_d  = digit_q;
    streak_d = streak_q;
    bcd_d    = bcd_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    done_d   = 1'b0;
    take     = 1'b0;

    unique case (state_q)
      StIdle: begin
        take = win_a || win_b;
      end
      StScanA, StScanB: begin
        if (slot_q == LastSlot) begin
          slot_d = '0;
          if (digit_q == LastDigit) begin
            done_d  = 1'b1;
            digit_d = '0;
            take    = win_a || win_b;
            if (!take) begin
              state_d = StIdle;
            end
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (take) begin
      state_d  = win_b ? StScanB : StScanA;
      slot_d   = '0;
      digit_d  = '0;
      streak_d = streak_arb;
      bcd_d    = snap_bcd;
      dp_d     = snap_dp;
      blank_d  = snap_blank;
    end
  end

  // State registers; async reset drops to IDLE so outputs blank immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      digit_q  <= '0;
      streak_q <= '0;
      bcd_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      digit_q  <= digit_d;
      streak_q <= streak_d;
      bcd_q    <= bcd_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

  sseg_digit_decode u_decode (
    .nibble_i (bcd_q[{digit_q, 2'b00} +: 4]),
    .dp_i     (dp_q[digit_q]),
    .blank_i  (blank_q[digit_q]),
    .sseg_o   (dec_sseg)
  );

  // Outputs: dark in IDLE and during the anti-ghosting blank phase of each slot.
  always_comb begin
    drive             = (state_q != StIdle) && (slot_q >= BlankEnd);
    bus_io.en         = drive ? ~(6'b000001 << digit_q) : EN_OFF;
    bus_io.sseg       = drive ? dec_sseg : SEG_BLANK;
    bus_io.a_gnt      = (state_q == StScanA);
    bus_io.b_gnt      = (state_q == StScanB);
    bus_io.frame_done = done_q;
  end

endmodule
